data_memory_sync: RTL and testbench

//  Parametrised synchronous data memory; successor to the fixed 256x16 data store.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_rd_pipe.sv | 44 ++++
 rtl/data_memory_sync.sv | 145 ++++++++++++++
 tb/tb_data_memory_sync.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the synchronous data memory.
package mem_pkg;

  // Controller state: hardware clear after reset, then normal service.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Pipeline bubble encoding used by the surrounding core.
  localparam logic [15:0] NOP_INSTR = 16'b1111000000000000;

  // Ceiling log2; used to size address indices and the clear counter.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Extra read-latency stages: a register line carrying {valid, err, data}.
module mem_rd_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic         err_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic         err_o,
  output logic [W-1:0] data_o
);

  logic         v_q [STAGES];
  logic         e_q [STAGES];
  logic [W-1:0] d_q [STAGES];

  // Shift the response line one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        e_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
      v_q[0] <= valid_i;
      e_q[0] <= err_i;
      d_q[0] <= data_i;
    end
  end

  assign valid_o = v_q[STAGES-1];
  assign err_o   = e_q[STAGES-1];
  assign data_o  = d_q[STAGES-1];

endmodule

// File: rtl/data_memory_sync.sv
// Synchronous data memory with post-reset clear, 1/2-cycle read latency,
// write-first bypass and out-of-range read flagging.
// Handshake: a request is taken whenever readEn/write is high on a rising edge
// while busy=0; there is no back-pressure. Each taken read yields exactly one
// outValid pulse RD_LAT cycles later, in request order.
module data_memory_sync
  import mem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 256,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] readAdd,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAdd,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              outValid,
  output logic              addrErr,
  output logic              busy
);

  localparam int                IDX_W    = clog2(DEPTH);
  localparam int                CNT_W    = IDX_W + 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              ready;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_accept;
  logic              wr_accept;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] rsp_data;

  logic              p_valid;
  logic              p_err;
  logic [DATA_W-1:0] p_data;

  logic [DATA_W-1:0] out_q;
  logic              valid_q;
  logic              err_q;

  assign ready       = (state_q == ST_READY);
  assign rd_in_range = ({1'b0, readAdd}  < DEPTH_X);
  assign wr_in_range = ({1'b0, writeAdd} < DEPTH_X);
  assign rd_accept   = readEn & ready;
  assign wr_accept   = write & ready & wr_in_range;
  assign rd_idx      = readAdd[IDX_W-1:0];
  assign wr_idx      = writeAdd[IDX_W-1:0];

  // Read data as seen at the request edge: zero when out of range, write-first on a hit.
  always_comb begin
    rsp_data = '0;
    if (rd_in_range) begin
      if (wr_accept && (writeAdd == readAdd)) begin
        rsp_data = in;
      end else begin
        rsp_data = mem_q[rd_idx];
      end
    end
  end

  // Controller: walk the clear counter over every word, then serve requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_READY;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  // Storage port: clear writes take priority; illegal write addresses are dropped.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q[IDX_W-1:0]] <= INIT_VAL;
    end else if (wr_accept) begin
      mem_q[wr_idx] <= in;
    end
  end

  // Additional latency beyond the first cycle lives in the read pipe.
  generate
    if (RD_LAT > 1) begin : g_pipe
      mem_rd_pipe #(
        .W      (DATA_W),
        .STAGES (RD_LAT - 1)
      ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .valid_i (rd_accept),
        .err_i   (~rd_in_range),
        .data_i  (rsp_data),
        .valid_o (p_valid),
        .err_o   (p_err),
        .data_o  (p_data)
      );
    end else begin : g_direct
      assign p_valid = rd_accept;
      assign p_err   = ~rd_in_range;
      assign p_data  = rsp_data;
    end
  endgenerate

  // Response register: out only changes on a valid response, addrErr only qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= p_valid;
      err_q   <= p_valid & p_err;
      if (p_valid) begin
        out_q <= p_data;
      end
    end
  end

  assign out      = out_q;
  assign outValid = valid_q;
  assign addrErr  = err_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench: two instances (RD_LAT=1 with INIT_VAL=0, RD_LAT=2 with
// INIT_VAL=A5A5) share one stimulus stream.
module tb_data_memory_sync;

  localparam logic [15:0] INIT1 = 16'h0000;
  localparam logic [15:0] INIT2 = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        readEn = 1'b0;
  logic [15:0] readAdd = '0;
  logic        write = 1'b0;
  logic [15:0] writeAdd = '0;
  logic [15:0] wdata = '0;

  logic [15:0] out1, out2;
  logic        ov1, ov2, ae1, ae2, busy1, busy2;

  int n_vec = 0;
  int n_err = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  data_memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1), .INIT_VAL(INIT1)) dut1 (
    .clk(clk), .reset(reset), .readEn(readEn), .readAdd(readAdd), .write(write),
    .writeAdd(writeAdd), .in(wdata), .out(out1), .outValid(ov1), .addrErr(ae1), .busy(busy1)
  );

  data_memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(2), .INIT_VAL(INIT2)) dut2 (
    .clk(clk), .reset(reset), .readEn(readEn), .readAdd(readAdd), .write(write),
    .writeAdd(writeAdd), .in(wdata), .out(out2), .outValid(ov2), .addrErr(ae2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    write = 1'b1; writeAdd = a; wdata = d;
    step();
    write = 1'b0;
  endtask

  // Single read; checks both latencies and that out holds afterwards.
  task automatic rd_chk(input logic [15:0] a, input logic [15:0] e1, input logic [15:0] e2,
                        input logic err);
    readEn = 1'b1; readAdd = a;
    step();
    readEn = 1'b0;
    check($sformatf("rd%0d v1", a), 32'(ov1), 1);
    check($sformatf("rd%0d d1", a), 32'(out1), 32'(e1));
    check($sformatf("rd%0d e1", a), 32'(ae1), 32'(err));
    check($sformatf("rd%0d v2 early", a), 32'(ov2), 0);
    step();
    check($sformatf("rd%0d v2", a), 32'(ov2), 1);
    check($sformatf("rd%0d d2", a), 32'(out2), 32'(e2));
    check($sformatf("rd%0d e2", a), 32'(ae2), 32'(err));
    check($sformatf("rd%0d v1 idle", a), 32'(ov1), 0);
    check($sformatf("rd%0d e1 idle", a), 32'(ae1), 0);
    check($sformatf("rd%0d d1 hold", a), 32'(out1), 32'(e1));
  endtask

  // Counts busy cycles after reset release while hammering the request inputs.
  task automatic clear_run(input string tag);
    int n;
    int pulses;
    n = 0;
    pulses = 0;
    readEn = 1'b1; readAdd = 16'd5;
    write = 1'b1; writeAdd = 16'd5; wdata = 16'h5555;
    while (busy1 && n < 400) begin
      step();
      n++;
      if (ov1 || ov2) pulses++;
    end
    readEn = 1'b0; write = 1'b0;
    check({tag, " busy cycles"}, 32'(n), 256);
    check({tag, " busy2"}, 32'(busy2), 0);
    check({tag, " pulses during clear"}, 32'(pulses), 0);
  endtask

  initial begin
    logic [15:0] sa [4];
    logic [15:0] sd [4];

    // 1: reset state, clear duration, every word at INIT_VAL.
    step();
    check("rst busy1", 32'(busy1), 1);
    check("rst busy2", 32'(busy2), 1);
    check("rst v1", 32'(ov1), 0);
    check("rst v2", 32'(ov2), 0);
    check("rst out1", 32'(out1), 0);
    check("rst err1", 32'(ae1), 0);
    reset = 1'b0;
    clear_run("init");

    for (int a = 0; a < 256; a++) begin
      readEn = 1'b1; readAdd = 16'(a);
      step();
      check("sweep v1", 32'(ov1), 1);
      check("sweep d1", 32'(out1), 32'(INIT1));
      check("sweep e1", 32'(ae1), 0);
      if (a > 0) begin
        check("sweep v2", 32'(ov2), 1);
        check("sweep d2", 32'(out2), 32'(INIT2));
      end
    end
    readEn = 1'b0;
    step();
    check("sweep tail v2", 32'(ov2), 1);
    check("sweep tail d2", 32'(out2), 32'(INIT2));
    check("sweep tail v1", 32'(ov1), 0);

    // 2: write then read.
    wr(16'd20, 16'h0001);
    rd_chk(16'd20, 16'h0001, 16'h0001, 1'b0);

    // 3: same-cycle write/read bypass.
    readEn = 1'b1; readAdd = 16'd54; write = 1'b1; writeAdd = 16'd54; wdata = 16'h0009;
    step();
    readEn = 1'b0; write = 1'b0;
    check("byp d1", 32'(out1), 16'h0009);
    step();
    check("byp v2", 32'(ov2), 1);
    check("byp d2", 32'(out2), 16'h0009);
    rd_chk(16'd54, 16'h0009, 16'h0009, 1'b0);

    // 3b: a write one cycle after the request must not reach the 2-cycle response.
    readEn = 1'b1; readAdd = 16'd54; write = 1'b1; writeAdd = 16'd54; wdata = 16'h00AA;
    step();
    readEn = 1'b0; wdata = 16'h00BB;
    check("byp2 d1", 32'(out1), 16'h00AA);
    step();
    write = 1'b0;
    check("byp2 v2", 32'(ov2), 1);
    check("byp2 d2", 32'(out2), 16'h00AA);
    rd_chk(16'd54, 16'h00BB, 16'h00BB, 1'b0);

    // 4: out-of-range read and write; boundary addresses.
    wr(16'd44, 16'h0044);
    wr(16'd300, 16'hDEAD);
    wr(16'd256, 16'hBEEF);
    rd_chk(16'd44, 16'h0044, 16'h0044, 1'b0);
    rd_chk(16'd300, 16'h0000, 16'h0000, 1'b1);
    rd_chk(16'd256, 16'h0000, 16'h0000, 1'b1);
    rd_chk(16'd0, INIT1, INIT2, 1'b0);
    wr(16'd255, 16'h0255);
    rd_chk(16'd255, 16'h0255, 16'h0255, 1'b0);
    rd_chk(16'hFFFF, 16'h0000, 16'h0000, 1'b1);

    // 5: back-to-back reads, responses in order.
    wr(16'd21, 16'h0021);
    wr(16'd23, 16'h0023);
    wr(16'd24, 16'h0024);
    sa[0] = 16'd20; sa[1] = 16'd21; sa[2] = 16'd23; sa[3] = 16'd24;
    sd[0] = 16'h0001; sd[1] = 16'h0021; sd[2] = 16'h0023; sd[3] = 16'h0024;
    for (int i = 0; i < 4; i++) begin
      readEn = 1'b1; readAdd = sa[i];
      step();
      check($sformatf("burst%0d v1", i), 32'(ov1), 1);
      check($sformatf("burst%0d d1", i), 32'(out1), 32'(sd[i]));
      if (i > 0) begin
        check($sformatf("burst%0d v2", i), 32'(ov2), 1);
        check($sformatf("burst%0d d2", i), 32'(out2), 32'(sd[i-1]));
      end
    end
    readEn = 1'b0;
    step();
    check("burst tail v2", 32'(ov2), 1);
    check("burst tail d2", 32'(out2), 16'h0024);
    check("burst tail v1", 32'(ov1), 0);

    // 6a: reset while a 2-cycle read is in flight.
    wr(16'd20, 16'h0077);
    readEn = 1'b1; readAdd = 16'd20;
    step();
    readEn = 1'b0;
    reset = 1'b1;
    #1;
    check("flight v1", 32'(ov1), 0);
    check("flight v2", 32'(ov2), 0);
    check("flight busy", 32'(busy1), 1);
    check("flight out1", 32'(out1), 0);
    step();
    check("flight v2 later", 32'(ov2), 0);
    reset = 1'b0;
    clear_run("flight");
    rd_chk(16'd20, INIT1, INIT2, 1'b0);

    // 6b: reset at clear count 100 restarts the full clear.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    check("mid busy before", 32'(busy1), 1);
    reset = 1'b1;
    step();
    check("mid busy held", 32'(busy1), 1);
    reset = 1'b0;
    clear_run("mid");
    rd_chk(16'd44, INIT1, INIT2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
